// File: rtl/rlk_credit_sched_pkg.sv
// Shared ECI definitions used by the receive-side credit logic and its helpers.
package eci_package;

    localparam int ECI_NUM_VCS     = 13;
    localparam int ECI_CREDIT_UNIT = 4;
    localparam int ECI_RX_LANES    = 7;

    typedef logic [3:0] VcNo_t;

endpackage

// File: rtl/rlk_credit_sched_vc_release_count.sv
// Per-VC popcount of lane release strobes; lanes naming a VC outside 0..NUM_VCS-1 add nothing.
module vc_release_count
    import eci_package::*;
#(
    parameter int NUM_VCS = ECI_NUM_VCS,
    parameter int LANES   = ECI_RX_LANES,
    parameter int INC_W   = 3
) (
    input  logic [LANES-1:0] rel_valid,
    input  VcNo_t            rel_vc_no [LANES-1:0],
    output logic [INC_W-1:0] inc       [NUM_VCS]
);

    always_comb begin
        for (int v = 0; v < NUM_VCS; v++) begin
            inc[v] = '0;
            for (int k = 0; k < LANES; k++) begin
                if (rel_valid[k] && (rel_vc_no[k] == VcNo_t'(v))) begin
                    inc[v] = inc[v] + INC_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/rlk_credit_sched.sv
// Credit-return scheduler: accumulates per-VC word releases and offers lo/hi credit bitmasks to the TLK.
module rlk_credit_sched
    import eci_package::*;
#(
    parameter int NUM_VCS     = ECI_NUM_VCS,
    parameter int CREDIT_UNIT = ECI_CREDIT_UNIT,
    parameter int CNT_W       = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    link_up,
    input  logic [ECI_RX_LANES-1:0] rel_valid,
    input  VcNo_t                   rel_vc_no [ECI_RX_LANES-1:0],
    output logic [7:0]              cr_data,
    output logic                    cr_hi,
    output logic                    cr_valid,
    input  logic                    cr_ready,
    output logic                    cnt_overflow
);

    typedef enum logic {IDLE, OFFER} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt     [NUM_VCS];
    logic [CNT_W:0]     cnt_sum [NUM_VCS];
    logic [2:0]         inc     [NUM_VCS];
    logic [NUM_VCS-1:0] pend;
    logic [NUM_VCS-1:0] debit;
    logic [NUM_VCS-1:0] sum_ovf;
    logic               pend_lo, pend_hi;
    logic               load, sel_hi, last_hi;
    logic [7:0]         load_data;

    // Sum is one bit wider than the counter; a debit only hits a pending VC so it cannot go negative.
    function automatic logic [CNT_W:0] cnt_update(input logic [CNT_W-1:0] c,
                                                   input logic [2:0]       i,
                                                   input logic             d);
        logic [CNT_W:0] r;
        r = {1'b0, c} + (CNT_W+1)'(i);
        if (d) r = r - (CNT_W+1)'(CREDIT_UNIT);
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W:0] s);
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    vc_release_count #(
        .NUM_VCS (NUM_VCS),
        .LANES   (ECI_RX_LANES),
        .INC_W   (3)
    ) u_release_count (
        .rel_valid (rel_valid),
        .rel_vc_no (rel_vc_no),
        .inc       (inc)
    );

    always_comb begin
        for (int v = 0; v < NUM_VCS; v++) begin
            pend[v] = (cnt[v] >= CNT_W'(CREDIT_UNIT));
        end
    end

    assign pend_lo   = |pend[7:0];
    assign pend_hi   = |pend[NUM_VCS-1:8];
    assign sel_hi    = (pend_lo && pend_hi) ? !last_hi : pend_hi;
    assign load_data = sel_hi ? 8'(pend[NUM_VCS-1:8]) : pend[7:0];
    assign cr_valid  = (state == OFFER);

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (link_up && (pend_lo || pend_hi)) begin
                    load      = 1'b1;
                    state_nxt = OFFER;
                end
            end
            OFFER: begin
                if (cr_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (!link_up) state_nxt = IDLE;
    end

    always_comb begin
        for (int v = 0; v < NUM_VCS; v++) begin
            debit[v]   = load && pend[v] && ((v >= 8) ? sel_hi : !sel_hi);
            cnt_sum[v] = cnt_update(cnt[v], inc[v], debit[v]);
            sum_ovf[v] = cnt_sum[v][CNT_W];
        end
    end

    // Output register and arbiter history
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            last_hi <= 1'b0;
            cr_data <= '0;
            cr_hi   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (!link_up) begin
                last_hi <= 1'b0;
            end else if (load) begin
                last_hi <= sel_hi;
                cr_data <= load_data;
                cr_hi   <= sel_hi;
            end
        end
    end

    // Release counters; the overflow flag is sticky until reset
    always_ff @(posedge clk) begin
        if (rst || !link_up) begin
            for (int v = 0; v < NUM_VCS; v++) cnt[v] <= '0;
        end else begin
            for (int v = 0; v < NUM_VCS; v++) cnt[v] <= sat_cnt(cnt_sum[v]);
        end
        if (rst) begin
            cnt_overflow <= 1'b0;
        end else if (link_up && (|sum_ovf)) begin
            cnt_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rlk_credit_sched.sv
// Randomized scoreboard bench for rlk_credit_sched against a cycle-level reference model.
module tb_rlk_credit_sched;
    import eci_package::*;

    localparam int NV   = 13;
    localparam int CU   = 4;
    localparam int CMAX = 63;

    logic        clk = 1'b0;
    logic        rst, link_up, cr_ready, cr_valid, cr_hi, cnt_overflow;
    logic [6:0]  rel_valid;
    VcNo_t       rel_vc_no [ECI_RX_LANES-1:0];
    logic [7:0]  cr_data;

    int          n_chk = 0;
    int          n_err = 0;
    bit          run_mon = 1'b0;

    int          m_cnt [NV];
    bit          m_busy, m_last_hi, m_ovf;
    logic [8:0]  exp_q [$];

    rlk_credit_sched #(.NUM_VCS(NV), .CREDIT_UNIT(CU), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .link_up      (link_up),
        .rel_valid    (rel_valid),
        .rel_vc_no    (rel_vc_no),
        .cr_data      (cr_data),
        .cr_hi        (cr_hi),
        .cr_valid     (cr_valid),
        .cr_ready     (cr_ready),
        .cnt_overflow (cnt_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: credits chosen from whole-VC word counts at each clock edge
    always @(posedge clk) begin
        int  add [NV];
        int  lo_mask, hi_mask, mask;
        bit  take_hi;
        if (rst) begin
            foreach (m_cnt[v]) m_cnt[v] = 0;
            m_busy = 0; m_last_hi = 0; m_ovf = 0;
            exp_q.delete();
        end else if (!link_up) begin
            foreach (m_cnt[v]) m_cnt[v] = 0;
            m_busy = 0; m_last_hi = 0;
            exp_q.delete();
        end else begin
            foreach (add[v]) add[v] = 0;
            for (int k = 0; k < 7; k++)
                if (rel_valid[k] && int'(rel_vc_no[k]) < NV) add[int'(rel_vc_no[k])]++;
            if (m_busy) begin
                if (cr_ready) m_busy = 0;
            end else begin
                lo_mask = 0; hi_mask = 0;
                for (int v = 0; v < 8; v++)  if (m_cnt[v] >= CU) lo_mask |= (1 << v);
                for (int v = 8; v < NV; v++) if (m_cnt[v] >= CU) hi_mask |= (1 << (v - 8));
                if (lo_mask != 0 || hi_mask != 0) begin
                    take_hi = (lo_mask != 0 && hi_mask != 0) ? !m_last_hi : (hi_mask != 0);
                    mask = take_hi ? hi_mask : lo_mask;
                    exp_q.push_back({take_hi, mask[7:0]});
                    m_busy = 1;
                    m_last_hi = take_hi;
                    for (int i = 0; i < 8; i++)
                        if (mask[i]) m_cnt[i + (take_hi ? 8 : 0)] -= CU;
                end
            end
            foreach (m_cnt[v]) begin
                m_cnt[v] += add[v];
                if (m_cnt[v] > CMAX) begin
                    m_cnt[v] = CMAX;
                    m_ovf = 1;
                end
            end
        end
    end

    // Monitor: compare what the DUT presents against the scoreboard queue
    always @(negedge clk) begin
        if (run_mon) begin
            chk("cr_valid", int'(cr_valid), int'(exp_q.size() != 0));
            if (cr_valid && exp_q.size() != 0) begin
                chk("cr_word", int'({cr_hi, cr_data}), int'(exp_q[0]));
                if (cr_ready && link_up && !rst) void'(exp_q.pop_front());
            end
            chk("cnt_overflow", int'(cnt_overflow), int'(m_ovf));
            for (int v = 0; v < NV; v++)
                chk($sformatf("cnt[%0d]", v), int'(dut.cnt[v]), m_cnt[v]);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse(input int a, input int na, input int b, input int nb);
        rel_valid = '0;
        for (int k = 0; k < 7; k++) begin
            if (k < na) begin
                rel_valid[k] = 1'b1;
                rel_vc_no[k] = VcNo_t'(a);
            end else if (k < na + nb) begin
                rel_valid[k] = 1'b1;
                rel_vc_no[k] = VcNo_t'(b);
            end
        end
        step();
        rel_valid = '0;
    endtask

    initial begin
        rst = 1'b1; link_up = 1'b0; cr_ready = 1'b0; rel_valid = '0;
        for (int k = 0; k < 7; k++) rel_vc_no[k] = '0;
        step();
        run_mon = 1'b1;
        @(negedge clk);
        chk("rst_cr_data", int'(cr_data), 0);
        chk("rst_cr_hi", int'(cr_hi), 0);
        #2;
        step();
        rst = 1'b0;
        step();
        link_up = 1'b1; cr_ready = 1'b1;
        step();

        // Single lo credit on VC 2
        pulse(2, 4, 0, 0);
        repeat (6) step();

        // VC 1 and VC 9 pend together: hi first, then lo
        pulse(1, 3, 9, 3);
        pulse(1, 1, 9, 1);
        repeat (8) step();

        // Back-pressure while VC 3 keeps releasing
        pulse(3, 4, 0, 0);
        cr_ready = 1'b0;
        repeat (10) pulse(3, 1, 0, 0);
        cr_ready = 1'b1;
        repeat (8) step();

        // Debit and release on VC 0 in the same cycle
        pulse(0, 5, 0, 0);
        pulse(0, 3, 0, 0);
        repeat (8) step();

        // Saturate VC 5 behind a stalled offer
        cr_ready = 1'b0;
        pulse(2, 4, 0, 0);
        repeat (2) step();
        repeat (9) pulse(5, 7, 0, 0);
        pulse(5, 1, 0, 0);
        repeat (3) step();
        cr_ready = 1'b1;
        repeat (40) step();

        // Link loss while an offer is outstanding
        cr_ready = 1'b0;
        pulse(4, 6, 0, 0);
        repeat (3) step();
        link_up = 1'b0;
        repeat (2) step();
        link_up = 1'b1; cr_ready = 1'b1;
        repeat (4) step();

        // Reset clears the sticky overflow
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();

        // Random traffic, including out-of-range VC numbers and link flaps
        repeat (2000) begin
            link_up  = ($urandom_range(0, 99) != 0);
            cr_ready = ($urandom_range(0, 2) != 0);
            for (int k = 0; k < 7; k++) begin
                rel_valid[k] = ($urandom_range(0, 3) == 0);
                rel_vc_no[k] = VcNo_t'($urandom_range(0, 15));
            end
            step();
        end

        // Heavy traffic with rare acceptance to drive counters into saturation
        link_up = 1'b1;
        repeat (1000) begin
            cr_ready = ($urandom_range(0, 7) == 0);
            for (int k = 0; k < 7; k++) begin
                rel_valid[k] = ($urandom_range(0, 1) == 0);
                rel_vc_no[k] = VcNo_t'($urandom_range(0, 15));
            end
            step();
        end

        rel_valid = '0;
        cr_ready = 1'b1;
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();
        run_mon = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
